rs_cmdeve_skid: RTL and testbench

Multi-channel, fully registered register slice for the cx_transfer command path (upstream to downstream) and event path (downstream to upstream).
- Every valid, data and ready output comes from a flop, so no combinational ready path crosses the block.
- Each path is a chain of STAGES two-entry skid buffers per channel, giving full throughput.
- Inserted between the LLDMA core and its external command/event interface to close timing across long routes.

---
 rtl/rs_cmdeve_skid.sv | 165 ++++++++++++++++
 tb/tb_rs_cmdeve_skid.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_cmdeve_skid.sv
// rs_cmdeve_skid: fully registered multi-channel cmd/eve register slice built from chained two-entry skid buffers
// Ports:
//   ext_clk, ext_reset_n             clock, asynchronous active-low reset
//   s_axis_cx_transfer_cmd_*         cmd path: upstream side (valid/data in, ready out)
//   s_axis_cx_transfer_cmd_*_rs      cmd path: downstream side (valid/data out, ready in)
//   m_axis_cx_transfer_eve_*_rs      eve path: downstream side (valid/data in, ready out)
//   m_axis_cx_transfer_eve_*         eve path: upstream side (valid/data out, ready in)
//   stat_clr, stat_cmd_cnt, stat_eve_cnt  per-channel output handshake counters (only with RS_CMDEVE_SKID_STAT_EN)

module rs_cmdeve_skid_stage #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  input  logic         out_rdy_i
);
  logic         m_vld_q, m_vld_d, k_vld_q, k_vld_d, rdy_q, rdy_d;
  logic [W-1:0] m_dat_q, m_dat_d, k_dat_q, k_dat_d;
  logic         in_acc, out_free;
  always_comb begin
    in_acc   = in_vld_i & rdy_q;
    out_free = ~m_vld_q | out_rdy_i;
    m_vld_d  = m_vld_q;
    m_dat_d  = m_dat_q;
    k_vld_d  = k_vld_q;
    k_dat_d  = k_dat_q;
    if (out_free) begin
      // rdy_q mirrors ~k_vld_q, so a pending skid beat and a new accept never coincide
      m_vld_d = k_vld_q | in_acc;
      m_dat_d = k_vld_q ? k_dat_q : (in_acc ? in_dat_i : m_dat_q);
      k_vld_d = 1'b0;
    end else if (in_acc) begin
      k_vld_d = 1'b1;
      k_dat_d = in_dat_i;
    end
    rdy_d = ~k_vld_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_vld_q <= 1'b0;
      m_dat_q <= '0;
      k_vld_q <= 1'b0;
      k_dat_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      m_vld_q <= m_vld_d;
      m_dat_q <= m_dat_d;
      k_vld_q <= k_vld_d;
      k_dat_q <= k_dat_d;
      rdy_q   <= rdy_d;
    end
  end
  assign in_rdy_o  = rdy_q;
  assign out_vld_o = m_vld_q;
  assign out_dat_o = m_dat_q;
endmodule

module rs_cmdeve_skid_pipe #(
  parameter int W      = 64,
  parameter int STAGES = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  input  logic         out_rdy_i
);
  logic         vld [STAGES+1];
  logic         rdy [STAGES+1];
  logic [W-1:0] dat [STAGES+1];
  assign vld[0]      = in_vld_i;
  assign dat[0]      = in_dat_i;
  assign in_rdy_o    = rdy[0];
  assign out_vld_o   = vld[STAGES];
  assign out_dat_o   = dat[STAGES];
  assign rdy[STAGES] = out_rdy_i;
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    rs_cmdeve_skid_stage #(.W(W)) u_stage (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .in_vld_i (vld[s]),
      .in_dat_i (dat[s]),
      .in_rdy_o (rdy[s]),
      .out_vld_o(vld[s+1]),
      .out_dat_o(dat[s+1]),
      .out_rdy_i(rdy[s+1])
    );
  end
endmodule

module rs_cmdeve_skid #(
  parameter int CH_NUM = 1,
  parameter int CMD_W  = 64,
  parameter int EVE_W  = 128,
  parameter int STAGES = 1
) (
  input  logic                    ext_clk,
  input  logic                    ext_reset_n,
`ifdef RS_CMDEVE_SKID_STAT_EN
  input  logic                    stat_clr,
  output logic [CH_NUM*32-1:0]    stat_cmd_cnt,
  output logic [CH_NUM*32-1:0]    stat_eve_cnt,
`endif
  input  logic [CH_NUM-1:0]       s_axis_cx_transfer_cmd_valid,
  input  logic [CH_NUM*CMD_W-1:0] s_axis_cx_transfer_cmd_data,
  output logic [CH_NUM-1:0]       s_axis_cx_transfer_cmd_ready,
  output logic [CH_NUM-1:0]       s_axis_cx_transfer_cmd_valid_rs,
  output logic [CH_NUM*CMD_W-1:0] s_axis_cx_transfer_cmd_data_rs,
  input  logic [CH_NUM-1:0]       s_axis_cx_transfer_cmd_ready_rs,
  input  logic [CH_NUM-1:0]       m_axis_cx_transfer_eve_valid_rs,
  input  logic [CH_NUM*EVE_W-1:0] m_axis_cx_transfer_eve_data_rs,
  output logic [CH_NUM-1:0]       m_axis_cx_transfer_eve_ready_rs,
  output logic [CH_NUM-1:0]       m_axis_cx_transfer_eve_valid,
  output logic [CH_NUM*EVE_W-1:0] m_axis_cx_transfer_eve_data,
  input  logic [CH_NUM-1:0]       m_axis_cx_transfer_eve_ready
);
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    rs_cmdeve_skid_pipe #(.W(CMD_W), .STAGES(STAGES)) u_cmd (
      .clk_i    (ext_clk),
      .rst_ni   (ext_reset_n),
      .in_vld_i (s_axis_cx_transfer_cmd_valid[c]),
      .in_dat_i (s_axis_cx_transfer_cmd_data[c*CMD_W +: CMD_W]),
      .in_rdy_o (s_axis_cx_transfer_cmd_ready[c]),
      .out_vld_o(s_axis_cx_transfer_cmd_valid_rs[c]),
      .out_dat_o(s_axis_cx_transfer_cmd_data_rs[c*CMD_W +: CMD_W]),
      .out_rdy_i(s_axis_cx_transfer_cmd_ready_rs[c])
    );
    rs_cmdeve_skid_pipe #(.W(EVE_W), .STAGES(STAGES)) u_eve (
      .clk_i    (ext_clk),
      .rst_ni   (ext_reset_n),
      .in_vld_i (m_axis_cx_transfer_eve_valid_rs[c]),
      .in_dat_i (m_axis_cx_transfer_eve_data_rs[c*EVE_W +: EVE_W]),
      .in_rdy_o (m_axis_cx_transfer_eve_ready_rs[c]),
      .out_vld_o(m_axis_cx_transfer_eve_valid[c]),
      .out_dat_o(m_axis_cx_transfer_eve_data[c*EVE_W +: EVE_W]),
      .out_rdy_i(m_axis_cx_transfer_eve_ready[c])
    );
`ifdef RS_CMDEVE_SKID_STAT_EN
    logic [31:0] cmd_cnt_q, cmd_cnt_d, eve_cnt_q, eve_cnt_d;
    always_comb begin
      cmd_cnt_d = stat_clr ? '0 : cmd_cnt_q + 32'(s_axis_cx_transfer_cmd_valid_rs[c] & s_axis_cx_transfer_cmd_ready_rs[c]);
      eve_cnt_d = stat_clr ? '0 : eve_cnt_q + 32'(m_axis_cx_transfer_eve_valid[c] & m_axis_cx_transfer_eve_ready[c]);
    end
    always_ff @(posedge ext_clk or negedge ext_reset_n) begin
      if (!ext_reset_n) begin
        cmd_cnt_q <= '0;
        eve_cnt_q <= '0;
      end else begin
        cmd_cnt_q <= cmd_cnt_d;
        eve_cnt_q <= eve_cnt_d;
      end
    end
    assign stat_cmd_cnt[c*32 +: 32] = cmd_cnt_q;
    assign stat_eve_cnt[c*32 +: 32] = eve_cnt_q;
`endif
  end
endmodule

// File: tb/tb_rs_cmdeve_skid.sv
// tb_rs_cmdeve_skid: randomized scoreboard bench for rs_cmdeve_skid (streams: 0/1 cmd ch0/ch1, 2/3 eve ch0/ch1)
module tb_rs_cmdeve_skid;
  localparam int CH = 2, ST = 2, CW = 64, EW = 128, NS = 4;
  typedef struct {logic [127:0] d; int cyc;} ent_t;
  ent_t         sb  [NS][$];
  logic [127:0] src [NS][$];
  int vp[NS], rp[NS], pops[NS];
  bit lat_exact[NS];
  int cyc = 0, nchk = 0, nfail = 0;
  logic ext_clk = 0, ext_reset_n = 0;
  logic [CH-1:0] cmd_valid, cmd_ready, cmd_valid_rs, cmd_ready_rs;
  logic [CH-1:0] eve_valid_rs, eve_ready_rs, eve_valid, eve_ready;
  logic [CH*CW-1:0] cmd_data, cmd_data_rs;
  logic [CH*EW-1:0] eve_data_rs, eve_data;
  logic bin_v[NS], bout_r[NS], dut_in_r[NS], dut_out_v[NS];
  logic [127:0] bin_d[NS], dut_out_d[NS];
`ifdef RS_CMDEVE_SKID_STAT_EN
  logic stat_clr = 0;
  logic [CH*32-1:0] stat_cmd_cnt, stat_eve_cnt;
`endif

  rs_cmdeve_skid #(.CH_NUM(CH), .CMD_W(CW), .EVE_W(EW), .STAGES(ST)) dut (
    .ext_clk                        (ext_clk),
    .ext_reset_n                    (ext_reset_n),
`ifdef RS_CMDEVE_SKID_STAT_EN
    .stat_clr                       (stat_clr),
    .stat_cmd_cnt                   (stat_cmd_cnt),
    .stat_eve_cnt                   (stat_eve_cnt),
`endif
    .s_axis_cx_transfer_cmd_valid   (cmd_valid),
    .s_axis_cx_transfer_cmd_data    (cmd_data),
    .s_axis_cx_transfer_cmd_ready   (cmd_ready),
    .s_axis_cx_transfer_cmd_valid_rs(cmd_valid_rs),
    .s_axis_cx_transfer_cmd_data_rs (cmd_data_rs),
    .s_axis_cx_transfer_cmd_ready_rs(cmd_ready_rs),
    .m_axis_cx_transfer_eve_valid_rs(eve_valid_rs),
    .m_axis_cx_transfer_eve_data_rs (eve_data_rs),
    .m_axis_cx_transfer_eve_ready_rs(eve_ready_rs),
    .m_axis_cx_transfer_eve_valid   (eve_valid),
    .m_axis_cx_transfer_eve_data    (eve_data),
    .m_axis_cx_transfer_eve_ready   (eve_ready)
  );

  always #5 ext_clk = ~ext_clk;
  always @(posedge ext_clk) cyc <= cyc + 1;

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      cmd_valid[c]             = bin_v[c];
      cmd_data[c*CW +: CW]     = bin_d[c][CW-1:0];
      cmd_ready_rs[c]          = bout_r[c];
      eve_valid_rs[c]          = bin_v[CH+c];
      eve_data_rs[c*EW +: EW]  = bin_d[CH+c];
      eve_ready[c]             = bout_r[CH+c];
      dut_in_r[c]              = cmd_ready[c];
      dut_in_r[CH+c]           = eve_ready_rs[c];
      dut_out_v[c]             = cmd_valid_rs[c];
      dut_out_v[CH+c]          = eve_valid[c];
      dut_out_d[c]             = {64'd0, cmd_data_rs[c*CW +: CW]};
      dut_out_d[CH+c]          = eve_data[c*EW +: EW];
    end
  end

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd(input int s);
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return s < CH ? {64'd0, v[63:0]} : v;
  endfunction

  // one cycle of stimulus: drive at negedge, then record beats the DUT will accept at the next edge
  task automatic step();
    @(negedge ext_clk);
    for (int s = 0; s < NS; s++) begin
      bin_v[s] = src[s].size() > 0 && $urandom_range(99) < vp[s];
      if (bin_v[s]) bin_d[s] = src[s][0];
      bout_r[s] = $urandom_range(99) < rp[s];
    end
    #1;
    for (int s = 0; s < NS; s++)
      if (bin_v[s] && dut_in_r[s]) begin
        sb[s].push_back('{src[s][0], cyc});
        void'(src[s].pop_front());
      end
  endtask

  task automatic refill();
    for (int s = 0; s < NS; s++)
      while (src[s].size() < 4) src[s].push_back(rnd(s));
  endtask

  // monitor: pops expected beats on output handshakes and checks AXI-stream stability
  logic pv[NS], pr[NS];
  logic [127:0] pd[NS];
  initial begin
    for (int s = 0; s < NS; s++) pv[s] = 0;
    forever begin
      @(negedge ext_clk);
      #2;
      for (int s = 0; s < NS; s++) begin
        if (!ext_reset_n) pv[s] = 0;
        else begin
          if (pv[s] && !pr[s]) begin
            chk(dut_out_v[s], $sformatf("retract s%0d", s), 128'(dut_out_v[s]), 128'(1));
            chk(dut_out_d[s] == pd[s], $sformatf("stable s%0d", s), dut_out_d[s], pd[s]);
          end
          if (dut_out_v[s] && bout_r[s]) begin
            if (sb[s].size() == 0) chk(0, $sformatf("unexpected beat s%0d", s), dut_out_d[s], 128'(0));
            else begin
              ent_t e;
              e = sb[s].pop_front();
              chk(dut_out_d[s] == e.d, $sformatf("data s%0d", s), dut_out_d[s], e.d);
              chk(lat_exact[s] ? (cyc - e.cyc == ST) : (cyc - e.cyc >= ST), $sformatf("latency s%0d", s), 128'(cyc - e.cyc), 128'(ST));
              pops[s]++;
            end
          end
          chk(sb[s].size() <= 2*ST, $sformatf("capacity s%0d", s), 128'(sb[s].size()), 128'(2*ST));
          pv[s] = dut_out_v[s];
          pr[s] = bout_r[s];
          pd[s] = dut_out_d[s];
        end
      end
    end
  end

  initial begin
    int p;
    bit hit;
    for (int s = 0; s < NS; s++) begin
      bin_v[s] = 0; bin_d[s] = '0; bout_r[s] = 0;
      vp[s] = 0; rp[s] = 100; lat_exact[s] = 0; pops[s] = 0;
    end
    repeat (3) @(negedge ext_clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      chk(!dut_out_v[s] && dut_out_d[s] == '0, $sformatf("reset out s%0d", s), dut_out_d[s], 128'(0));
      chk(!dut_in_r[s], $sformatf("reset ready s%0d", s), 128'(dut_in_r[s]), 128'(0));
    end
    @(negedge ext_clk) ext_reset_n = 1;
    #1;
    for (int s = 0; s < NS; s++) chk(!dut_in_r[s], $sformatf("ready at release s%0d", s), 128'(dut_in_r[s]), 128'(0));
    @(negedge ext_clk);
    #1;
    for (int s = 0; s < NS; s++) chk(dut_in_r[s], $sformatf("ready after edge s%0d", s), 128'(dut_in_r[s]), 128'(1));

    // streaming cmd ch0 0x1..0x10
    for (int i = 1; i <= 16; i++) src[0].push_back(128'(i));
    vp[0] = 100; lat_exact[0] = 1; p = pops[0];
    repeat (16) begin
      step();
      chk(dut_in_r[0], "stream ready", 128'(dut_in_r[0]), 128'(1));
    end
    vp[0] = 0;
    repeat (ST + 3) step();
    chk(pops[0] - p == 16, "stream count", 128'(pops[0] - p), 128'(16));
    lat_exact[0] = 0;

    // backpressure cmd ch1 from beat 0x3
    for (int i = 3; i <= 12; i++) src[1].push_back(128'(i));
    rp[1] = 0; vp[1] = 100; p = pops[1];
    repeat (12) step();
    chk(sb[1].size() == 2*ST, "bp buffered", 128'(sb[1].size()), 128'(2*ST));
    chk(!dut_in_r[1], "bp ready low", 128'(dut_in_r[1]), 128'(0));
    chk(dut_out_v[1] && dut_out_d[1] == 128'(3), "bp head", dut_out_d[1], 128'(3));
    rp[1] = 100;
    repeat (2*ST) begin
      step();
      chk(dut_out_v[1], "bp no bubble", 128'(dut_out_v[1]), 128'(1));
    end
    repeat (12) step();
    vp[1] = 0;
    chk(pops[1] - p == 10, "bp count", 128'(pops[1] - p), 128'(10));

    // isolation: eve ch0 stalled, eve ch1 streams 0xA0..0xAF
    for (int i = 0; i < 4; i++) src[2].push_back(128'(8'h50 + i));
    for (int i = 0; i < 16; i++) src[3].push_back(128'(8'hA0 + i));
    rp[2] = 0; vp[2] = 100; vp[3] = 100; lat_exact[3] = 1; p = pops[3];
    repeat (16) begin
      step();
      chk(dut_in_r[3], "iso ch1 ready", 128'(dut_in_r[3]), 128'(1));
    end
    vp[3] = 0;
    repeat (ST + 2) step();
    chk(pops[3] - p == 16, "iso ch1 count", 128'(pops[3] - p), 128'(16));
    chk(dut_out_v[2] && dut_out_d[2] == 128'(8'h50), "iso ch0 held", dut_out_d[2], 128'(8'h50));
    lat_exact[3] = 0; rp[2] = 100;
    repeat (10) step();
    vp[2] = 0;
    chk(sb[2].size() == 0 && src[2].size() == 0, "iso ch0 drained", 128'(sb[2].size()), 128'(0));

    // random traffic on all streams
    for (int s = 0; s < NS; s++) begin vp[s] = 70; rp[s] = 60; end
    repeat (5000) begin refill(); step(); end
    for (int s = 0; s < NS; s++) begin vp[s] = 0; rp[s] = 100; end
    repeat (20) step();
    for (int s = 0; s < NS; s++) chk(sb[s].size() == 0, $sformatf("random drained s%0d", s), 128'(sb[s].size()), 128'(0));

    // asynchronous reset mid-traffic
    for (int s = 0; s < NS; s++) begin vp[s] = 100; rp[s] = 50; end
    repeat (20) begin refill(); step(); end
    @(posedge ext_clk);
    #3 ext_reset_n = 0;
    #1;
    for (int s = 0; s < NS; s++) begin
      chk(!dut_out_v[s] && dut_out_d[s] == '0 && !dut_in_r[s], $sformatf("async reset s%0d", s), dut_out_d[s], 128'(0));
      sb[s].delete(); src[s].delete();
      bin_v[s] = 0; vp[s] = 0; rp[s] = 100;
    end
    repeat (2) @(negedge ext_clk);
    @(negedge ext_clk) ext_reset_n = 1;
    @(negedge ext_clk);
    for (int i = 0; i < 4; i++) src[0].push_back(128'(8'h71 + i));
    vp[0] = 100; p = pops[0];
    repeat (10) step();
    vp[0] = 0;
    chk(pops[0] - p == 4, "post reset count", 128'(pops[0] - p), 128'(4));

`ifdef RS_CMDEVE_SKID_STAT_EN
    @(negedge ext_clk) stat_clr = 1;
    @(negedge ext_clk) stat_clr = 0;
    #1 chk(stat_cmd_cnt[31:0] == 0, "stat cleared", 128'(stat_cmd_cnt[31:0]), 128'(0));
    for (int i = 0; i < 5; i++) src[0].push_back(rnd(0));
    vp[0] = 100;
    repeat (5 + ST + 2) step();
    vp[0] = 0;
    chk(stat_cmd_cnt[31:0] == 5, "stat five", 128'(stat_cmd_cnt[31:0]), 128'(5));
    src[0].push_back(rnd(0));
    vp[0] = 100; hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step();
      hit = dut_out_v[0] && bout_r[0];
    end
    vp[0] = 0;
    chk(hit, "stat sixth seen", 128'(hit), 128'(1));
    stat_clr = 1;
    @(posedge ext_clk);
    #1 stat_clr = 0;
    @(negedge ext_clk);
    #1 chk(stat_cmd_cnt[31:0] == 0, "stat clear wins", 128'(stat_cmd_cnt[31:0]), 128'(0));
`endif

    repeat (3) @(negedge ext_clk);
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
